seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one seven-segment decoder between NUM_DIGITS common-anode/cathode digit positions.
- Holds a double-buffered BCD/hex display word.
- Presents one nibble at a time on the decoder inputs (w = MSB .. z = LSB).
- Drives one-hot digit enables with a blanking guard interval before each digit, so the decoder's gate delays settle before a digit lights.
- Sits between the register/bus logic that writes display values and the decoder + digit drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (2..8)
REFRESH_DIV, 1000, clock cycles each digit is lit per scan slot (>=1)
BLANK_CYCLES, 2, clock cycles all digits are off before each slot (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
load  input  1  one-cycle strobe: capture value and blank_lz into the pending buffer
value  input  4*NUM_DIGITS  display word; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant
blank_lz  input  1  captured with load; 1 = suppress leading zeros
load_ack  output  1  one-cycle pulse, registered, the cycle after load
dec_w, dec_x, dec_y, dec_z  output  1 each  nibble of the current digit to the shared decoder (dec_w = bit 3)
dig_en  output  NUM_DIGITS  one-hot active-high digit enable; all zero outside SHOW
frame_done  output  1  one-cycle pulse when a full scan of all digits completes

Behaviour:
Reset (rst_n=0 at an edge), applied in any state including mid-frame:
- state=IDLE; digit index=0; dig_en=0; dec_* = 0; load_ack=0; frame_done=0.
- Active and pending buffers cleared; pending_valid=0; lz flags=0.

States:
- IDLE: all outputs held at reset values.
  - load seen: copy value/blank_lz straight to the active buffer, go to BLANK with index 0.
- BLANK: dig_en=0; dec_* already show active nibble[index]. Lasts exactly BLANK_CYCLES cycles, then SHOW.
- SHOW: dig_en[index]=1 unless the digit is suppressed (then dig_en=0, slot timing unchanged). Lasts exactly REFRESH_DIV cycles.
  - index < NUM_DIGITS-1: index+1, go to BLANK.
  - index = NUM_DIGITS-1: index wraps to 0, go to BLANK. On that same edge frame_done=1 for one cycle, and if pending_valid the pending buffer is copied to active and pending_valid clears.

Timing:
- One slot = BLANK_CYCLES + REFRESH_DIV cycles.
- One frame = NUM_DIGITS * slot.
- dec_* change only on the BLANK-entry edge, never while dig_en is nonzero. This is the anti-ghosting guarantee.

Load handling:
- load outside IDLE writes the pending buffer and sets pending_valid. The active word changes only at a frame boundary, so no tearing.
- A second load before the boundary overwrites pending; last write wins.
- load_ack pulses for every load, including in IDLE.
- load on the same edge as the frame-boundary swap: the swap takes the old pending; the new value goes to pending for the next frame.

Leading-zero suppression (active lz flag = 1):
- Digit i (i >= 1) is suppressed iff nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never suppressed.
- Evaluated combinationally from the active buffer.

Counters:
- Slot counter width is ceil(log2(max(REFRESH_DIV, BLANK_CYCLES)+1)). It wraps to 0 on every state change.
- No running state out of IDLE except via reset.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, slot=5, frame=20):
1. Reset held 3 cycles, then released with no load -> dig_en=0000, dec_*=0, frame_done never pulses over 50 cycles.
2. load with value=16'h4321, blank_lz=0 -> load_ack the next cycle; then 1 cycle dig_en=0000 with dec=1, then 4 cycles dig_en=0001; digit 1: dec=2, dig_en=0010; ...; frame_done at cycle 20 after entry; repeats identically.
3. Mid-frame load of 16'h00A7 during digit 1 SHOW -> digits 1..3 keep showing 2,3,4 in this frame; the swap happens on the frame_done edge; the next frame shows 7, A, 0, 0.
4. blank_lz=1 with value=16'h0050 -> digits 0 and 1 lit (dec 0, then 5); digits 2 and 3 have dig_en=0000 during their SHOW slots; frame still 20 cycles. Value 16'h0000 -> only digit 0 lit, showing 0.
5. Two loads (16'h1111, then 16'h2222) within one frame, the second on the exact frame_done edge -> next frame shows 1111, the following frame 2222; load_ack pulses twice.
6. rst_n low for 1 cycle during digit 2 SHOW -> the next cycle dig_en=0000 and dec=0, state IDLE; buffers cleared; the next load restarts from digit 0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment scan controller: one shared decoder, NUM_DIGITS time-multiplexed digits,
// double-buffered display word, blanking guard before every digit, optional leading-zero blanking.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    blank_lz,
   output logic                    load_ack,
   output logic                    dec_w,
   output logic                    dec_x,
   output logic                    dec_y,
   output logic                    dec_z,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_done
);

   localparam int VW      = 4 * NUM_DIGITS;
   localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [IW-1:0]     idx_r, idx_nxt_s;
   logic [CW-1:0]     cnt_r, cnt_nxt_s;
   logic              frame_end_s;

   logic [VW-1:0]     active_r, active_nxt_s;
   logic              active_lz_r, active_lz_nxt_s;
   logic [VW-1:0]     pending_r, pending_nxt_s;
   logic              pending_lz_r, pending_lz_nxt_s;
   logic              pending_valid_r, pending_valid_nxt_s;

   logic [NUM_DIGITS-1:0] supp_s;
   logic [3:0]            dec_nxt_s;
   logic [NUM_DIGITS-1:0] dig_en_nxt_s;

   logic [3:0]            dec_r;
   logic [NUM_DIGITS-1:0] dig_en_r;
   logic                  load_ack_r;
   logic                  frame_done_r;

   function automatic logic [3:0] nibble_at(input logic [VW-1:0] w, input logic [IW-1:0] i);
      nibble_at = 4'h0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (i == IW'(k)) begin
            nibble_at = w[4*k +: 4];
         end
      end
   endfunction

   // Slot sequencing: state, digit index and the per-state cycle counter.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      cnt_nxt_s   = cnt_r + CW'(1);
      frame_end_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s = '0;
            if (load) begin
               state_nxt_s = ST_BLANK;
               idx_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BLANK: begin
            if (cnt_r == BLANK_LAST) begin
               state_nxt_s = ST_SHOW;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (cnt_r == SHOW_LAST) begin
               state_nxt_s = ST_BLANK;
               cnt_nxt_s   = '0;
               if (idx_r == LAST_IDX) begin
                  idx_nxt_s   = '0;
                  frame_end_s = 1'b1;
               end else begin
                  idx_nxt_s = idx_r + IW'(1);
               end
            end else begin
               state_nxt_s = ST_SHOW;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = '0;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Double buffer: the active word only changes when leaving IDLE or at a frame boundary.
   always_comb begin
      active_nxt_s        = active_r;
      active_lz_nxt_s     = active_lz_r;
      pending_nxt_s       = pending_r;
      pending_lz_nxt_s    = pending_lz_r;
      pending_valid_nxt_s = pending_valid_r;
      if (state_r == ST_IDLE) begin
         if (load) begin
            active_nxt_s    = value;
            active_lz_nxt_s = blank_lz;
         end else begin
            active_nxt_s    = active_r;
         end
      end else begin
         if (frame_end_s && pending_valid_r) begin
            active_nxt_s        = pending_r;
            active_lz_nxt_s     = pending_lz_r;
            pending_valid_nxt_s = 1'b0;
         end else begin
            active_nxt_s        = active_r;
         end
         // A load on the swap edge lands in pending after the old pending moved out.
         if (load) begin
            pending_nxt_s       = value;
            pending_lz_nxt_s    = blank_lz;
            pending_valid_nxt_s = 1'b1;
         end else begin
            pending_nxt_s       = pending_r;
         end
      end
   end

   // Leading-zero suppression mask and next decoder/enable values.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      supp_s     = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (active_r[4*i +: 4] == 4'h0);
         supp_s[i]  = active_lz_r && zero_above && (i != 0);
      end
      dig_en_nxt_s = '0;
      dec_nxt_s    = dec_r;
      // Decoder inputs only move on BLANK entry, so they are settled before any digit lights.
      if ((state_nxt_s == ST_BLANK) && (state_r != ST_BLANK)) begin
         dec_nxt_s = nibble_at(active_nxt_s, idx_nxt_s);
      end else begin
         dec_nxt_s = dec_r;
      end
      if ((state_nxt_s == ST_SHOW) && !supp_s[idx_nxt_s]) begin
         dig_en_nxt_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt_s;
      end else begin
         dig_en_nxt_s = '0;
      end
   end

   // State, counter and buffer registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r         <= ST_IDLE;
         idx_r           <= '0;
         cnt_r           <= '0;
         active_r        <= '0;
         active_lz_r     <= 1'b0;
         pending_r       <= '0;
         pending_lz_r    <= 1'b0;
         pending_valid_r <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         idx_r           <= idx_nxt_s;
         cnt_r           <= cnt_nxt_s;
         active_r        <= active_nxt_s;
         active_lz_r     <= active_lz_nxt_s;
         pending_r       <= pending_nxt_s;
         pending_lz_r    <= pending_lz_nxt_s;
         pending_valid_r <= pending_valid_nxt_s;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dec_r        <= 4'h0;
         dig_en_r     <= '0;
         load_ack_r   <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         dec_r        <= dec_nxt_s;
         dig_en_r     <= dig_en_nxt_s;
         load_ack_r   <= load;
         frame_done_r <= frame_end_s;
      end
   end

   assign dec_w      = dec_r[3];
   assign dec_x      = dec_r[2];
   assign dec_y      = dec_r[1];
   assign dec_z      = dec_r[0];
   assign dig_en     = dig_en_r;
   assign load_ack   = load_ack_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed plus random stimulus compared every cycle against
// a frame-position model (phase within a 20-cycle frame) of the display timeline.
module tb_seven_seg_scan_ctrl;

   localparam int N    = 4;
   localparam int RDIV = 4;
   localparam int BLK  = 1;
   localparam int SLOT = BLK + RDIV;
   localparam int FRM  = N * SLOT;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load = 1'b0;
   logic [15:0]   value = 16'h0;
   logic          blank_lz = 1'b0;
   logic          load_ack, dec_w, dec_x, dec_y, dec_z, frame_done;
   logic [N-1:0]  dig_en;

   int tests = 0;
   int fails = 0;

   // Reference model state
   bit          m_run;
   int          m_phase;
   logic [15:0] m_active, m_pending;
   bit          m_lz, m_plz, m_pv;
   logic        e_ack, e_fd;

   seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_lz(blank_lz),
      .load_ack(load_ack), .dec_w(dec_w), .dec_x(dec_x), .dec_y(dec_y), .dec_z(dec_z),
      .dig_en(dig_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      bit boundary;
      e_ack = 1'b0;
      e_fd  = 1'b0;
      if (!rst_n) begin
         m_run = 0; m_phase = 0; m_active = 16'h0; m_pending = 16'h0;
         m_lz = 0; m_plz = 0; m_pv = 0;
      end else begin
         e_ack = load;
         if (!m_run) begin
            if (load) begin
               m_run = 1; m_phase = 0; m_active = value; m_lz = blank_lz;
            end
         end else begin
            boundary = (m_phase == FRM - 1);
            m_phase  = (m_phase + 1) % FRM;
            e_fd     = boundary;
            if (boundary && m_pv) begin
               m_active = m_pending; m_lz = m_plz; m_pv = 0;
            end
            if (load) begin
               m_pending = value; m_plz = blank_lz; m_pv = 1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic cycle();
      int digit, pos;
      logic [3:0] e_dec;
      logic [N-1:0] e_en;
      @(posedge clk);
      model_step();
      #1;
      e_dec = 4'h0;
      e_en  = '0;
      if (m_run) begin
         digit = m_phase / SLOT;
         pos   = m_phase % SLOT;
         e_dec = 4'((m_active >> (4 * digit)) & 16'hF);
         if (pos >= BLK && !(m_lz && digit >= 1 && (m_active >> (4 * digit)) == 16'h0))
            e_en = N'(1 << digit);
      end
      chk("dig_en", {4'h0, dig_en}, {4'h0, e_en});
      chk("dec", {4'h0, dec_w, dec_x, dec_y, dec_z}, {4'h0, e_dec});
      chk("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
      chk("load_ack", {7'h0, load_ack}, {7'h0, e_ack});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_load(input logic [15:0] v, input logic lz);
      load = 1'b1; value = v; blank_lz = lz;
      cycle();
      load = 1'b0;
   endtask

   // Advance until the model's next edge will leave it at phase ph (bounded).
   task automatic run_to_phase(input int ph);
      int k;
      for (k = 0; k < 2 * FRM; k++) begin
         if (m_run && ((m_phase + 1) % FRM) == ph) break;
         cycle();
      end
      tests++;
      assert (k < 2 * FRM) else begin
         fails++;
         $error("FAIL phase_wait: observed timeout expected phase %0d", ph);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(50);

      do_load(16'h4321, 1'b0);
      run(45);

      run_to_phase(7);
      do_load(16'h00A7, 1'b0);
      run(45);

      do_load(16'h0050, 1'b1);
      run(45);
      do_load(16'h0000, 1'b1);
      run(45);

      run_to_phase(3);
      do_load(16'h1111, 1'b0);
      run_to_phase(0);
      do_load(16'h2222, 1'b0);
      run(45);

      run_to_phase(12);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      run(4);
      do_load(16'h5A3C, 1'b0);
      run(25);

      for (int i = 0; i < 600; i++) begin
         load     = ($urandom_range(0, 19) == 0);
         value    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         blank_lz = 1'($urandom_range(0, 1));
         rst_n    = ($urandom_range(0, 199) != 0);
         cycle();
      end
      load  = 1'b0;
      rst_n = 1'b1;
      run(30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
